// File: rtl/avalon_dmem_pkg.sv
// Shared types and helpers for the data-memory Avalon bridge.
// Lane masks and load extension are computed at 64-bit width and trimmed by users.
package avalon_dmem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      WAIT_DATA,
      DONE
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   function automatic logic [7:0] lane_mask(
      input logic [1:0] size,
      input logic [2:0] lo
   );
      logic [7:0] m;
      unique case (size)
         SZ_B:    m = 8'h01 << lo;
         SZ_H:    m = 8'h03 << lo;
         SZ_W:    m = 8'h0F << lo;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic [63:0] extend(
      input logic [63:0] data,
      input logic [1:0]  size,
      input logic        uns
   );
      logic [63:0] r;
      unique case (size)
         SZ_B: r = uns ? {56'd0, data[7:0]}
                       : {{56{data[7]}}, data[7:0]};
         SZ_H: r = uns ? {48'd0, data[15:0]}
                       : {{48{data[15]}}, data[15:0]};
         SZ_W: r = uns ? {32'd0, data[31:0]}
                       : {{32{data[31]}}, data[31:0]};
         default: r = data;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/avalon_dmem_bridge_if.sv
// Avalon-MM master bundle used by the data-memory bridge.
// The bridge drives the command side, the memory drives the response side.
interface avalon_dmem_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int LANES = DATA_W / 8;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [LANES-1:0]  byteenable;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              waitrequest;
   logic              readdatavalid;

   modport master (
      output address, read, write,
      output byteenable, writedata,
      input  readdata, waitrequest,
      input  readdatavalid
   );

   modport slave (
      input  address, read, write,
      input  byteenable, writedata,
      output readdata, waitrequest,
      output readdatavalid
   );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byteenable/replication and load extraction.
// Purely combinational; lo is the byte offset within one bus word.
module dmem_lane_align
   import avalon_dmem_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int LANES  = DATA_W / 8,
   localparam int LW     = $clog2(LANES)
) (
   input  logic [1:0]        size,
   input  logic [LW-1:0]     lo,
   input  logic              uns,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [LANES-1:0]  be,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [7:0]        mask;
   logic [DATA_W-1:0] shifted;
   logic [63:0]       ext;

   assign mask = lane_mask(size, 3'(lo));
   assign be   = mask[LANES-1:0];

   // Replicate the store operand so every lane carries it.
   always_comb begin
      wdata_rep = wdata;
      unique case (size)
         SZ_B:    wdata_rep = {LANES{wdata[7:0]}};
         SZ_H:    wdata_rep = {(LANES/2){wdata[15:0]}};
         SZ_W:    wdata_rep = {(LANES/4){wdata[31:0]}};
         default: wdata_rep = wdata;
      endcase
   end

   assign shifted   = rdata >> {lo, 3'b000};
   assign ext       = extend(64'(shifted), size, uns);
   assign rdata_ext = ext[DATA_W-1:0];

   if (DATA_W < 64) begin : g_trim
      logic unused_hi;
      assign unused_hi = ^{ext[63:DATA_W], mask[7:LANES]};
   end

endmodule

// File: rtl/avalon_dmem_bridge.sv
// MEM-stage to Avalon-MM bridge with stall gating, alignment check and timeout.
// Command outputs are registered; enable_out is combinational from state.
module avalon_dmem_bridge
   import avalon_dmem_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int N_STAGES = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_rd,
   input  logic                req_wr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [1:0]          req_size,
   input  logic                req_unsigned,
   input  logic [N_STAGES-1:0] enable_in,
   output logic [N_STAGES-1:0] enable_out,
   output logic [DATA_W-1:0]   rdata_out,
   output logic                err,
   avalon_dmem_bridge_if.master avm
);

   localparam int LANES = DATA_W / 8;
   localparam int LW    = $clog2(LANES);
   localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t            st, st_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              is_rd_q, is_rd_n;
   logic [1:0]        size_q, size_n;
   logic [LW-1:0]     lo_q, lo_n;
   logic              uns_q, uns_n;
   logic              rd_n, wr_n, err_n;
   logic [ADDR_W-1:0] adr_n;
   logic [LANES-1:0]  be_n;
   logic [DATA_W-1:0] wd_n, rdat_n;

   logic              req_any, req_bad;
   logic              misal, size_bad, tmo, pass;
   logic [1:0]        al_size;
   logic [LW-1:0]     al_lo;
   logic [LANES-1:0]  al_be;
   logic [DATA_W-1:0] al_wd, al_rd;

   assign req_any  = req_rd | req_wr;
   assign size_bad = (req_size == SZ_D) && (DATA_W != 64);
   assign req_bad  = (req_rd & req_wr) | size_bad | misal;
   assign tmo      = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT));

   // Natural-alignment check on the incoming request.
   always_comb begin
      misal = 1'b0;
      unique case (req_size)
         SZ_B:    misal = 1'b0;
         SZ_H:    misal = req_addr[0];
         SZ_W:    misal = |req_addr[1:0];
         default: misal = |req_addr[2:0];
      endcase
   end

   // Live request steers lanes in IDLE; the latched command does afterwards.
   assign al_size = (st == IDLE) ? req_size : size_q;
   assign al_lo   = (st == IDLE) ? req_addr[LW-1:0] : lo_q;

   dmem_lane_align #(.DATA_W(DATA_W)) u_align (
      .size      (al_size),
      .lo        (al_lo),
      .uns       (uns_q),
      .wdata     (req_wdata),
      .rdata     (avm.readdata),
      .be        (al_be),
      .wdata_rep (al_wd),
      .rdata_ext (al_rd)
   );

   // Pipeline moves only when idle without a request or on completion.
   assign pass = (st == DONE) || ((st == IDLE) && !req_any);
   assign enable_out = pass ? enable_in : '0;

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      is_rd_n = is_rd_q;
      size_n  = size_q;
      lo_n    = lo_q;
      uns_n   = uns_q;
      rd_n    = avm.read;
      wr_n    = avm.write;
      adr_n   = avm.address;
      be_n    = avm.byteenable;
      wd_n    = avm.writedata;
      rdat_n  = rdata_out;
      err_n   = 1'b0;
      unique case (st)
         IDLE: begin
            if (req_any && req_bad) begin
               st_n   = DONE;
               err_n  = 1'b1;
               rdat_n = '0;
            end else if (req_any) begin
               st_n    = CMD;
               cnt_n   = '0;
               rd_n    = req_rd;
               wr_n    = req_wr;
               adr_n   = {req_addr[ADDR_W-1:LW], {LW{1'b0}}};
               be_n    = al_be;
               wd_n    = al_wd;
               is_rd_n = req_rd;
               size_n  = req_size;
               lo_n    = req_addr[LW-1:0];
               uns_n   = req_unsigned;
            end
         end
         CMD: begin
            cnt_n = cnt + CW'(1);
            if (tmo) begin
               st_n   = DONE;
               err_n  = 1'b1;
               rdat_n = '0;
               rd_n   = 1'b0;
               wr_n   = 1'b0;
            end else if (!avm.waitrequest) begin
               rd_n = 1'b0;
               wr_n = 1'b0;
               if (!is_rd_q) begin
                  st_n = DONE;
               end else if (avm.readdatavalid) begin
                  st_n   = DONE;
                  rdat_n = al_rd;
               end else begin
                  st_n = WAIT_DATA;
               end
            end
         end
         WAIT_DATA: begin
            cnt_n = cnt + CW'(1);
            if (tmo) begin
               st_n   = DONE;
               err_n  = 1'b1;
               rdat_n = '0;
            end else if (avm.readdatavalid) begin
               st_n   = DONE;
               rdat_n = al_rd;
            end
         end
         DONE:    st_n = IDLE;
         default: st_n = IDLE;
      endcase
   end

   // State, command and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st             <= IDLE;
         cnt            <= '0;
         is_rd_q        <= 1'b0;
         size_q         <= SZ_B;
         lo_q           <= '0;
         uns_q          <= 1'b0;
         avm.read       <= 1'b0;
         avm.write      <= 1'b0;
         avm.address    <= '0;
         avm.byteenable <= '0;
         avm.writedata  <= '0;
         rdata_out      <= '0;
         err            <= 1'b0;
      end else begin
         st             <= st_n;
         cnt            <= cnt_n;
         is_rd_q        <= is_rd_n;
         size_q         <= size_n;
         lo_q           <= lo_n;
         uns_q          <= uns_n;
         avm.read       <= rd_n;
         avm.write      <= wr_n;
         avm.address    <= adr_n;
         avm.byteenable <= be_n;
         avm.writedata  <= wd_n;
         rdata_out      <= rdat_n;
         err            <= err_n;
      end
   end

endmodule
